// File: rtl/loader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | loader_pkg : shared constants and state codes for the UART loader       |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LEN_HI = 3'd1;
  localparam state_t S_LEN_LO = 3'd2;
  localparam state_t S_DAT_HI = 3'd3;
  localparam state_t S_DAT_LO = 3'd4;
  localparam state_t S_CSUM   = 3'd5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int CLKS_PER_BIT = clks_per_bit(50_000_000, 115_200);

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_rx  : 8N1 receiver with 2-flop synchronizer and glitch rejection   |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // [1:0] is the synchronizer, [2] is history for falling-edge detection
  logic [2:0]    sync_q;
  logic [1:0]    st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          valid_q;
  logic          ferr_q;

  logic w_rx;
  logic w_prev;
  assign w_rx   = sync_q[1];
  assign w_prev = sync_q[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 3'b111;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd};
      valid_q <= 1'b0;
      case (st_q)
        RX_IDLE: begin
          if (w_prev && !w_rx) begin
            cnt_q <= '0;
            st_q  <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            st_q  <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            sh_q  <= {w_rx, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            valid_q <= 1'b1;
            ferr_q  <= !w_rx;
            st_q    <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: st_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_byte  = sh_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_prog_loader : framed UART loader writing the 16-bit instr memory   |
// | Revision         : 1.0                                                  |
// +-------------------------------------------------------------------------+
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int MAX_WORDS   = 4096,
  parameter int TIMEOUT_CYC = 16 * (CLK_HZ / BAUD) * 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    sum_q, sum_d;
  logic [15:0]   wc_q, wc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          wren_q, wren_d;

  logic [15:0] w_len_n;
  assign w_len_n = {len_q[15:8], rx_byte};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    sum_d   = sum_q;
    wc_d    = wc_q;
    done_d  = done_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    tmo_d   = (state_q == S_IDLE) ? '0 : tmo_q + TW'(1);
    if (rx_valid) begin
      // tmo counts cycles since the last rx_valid, so it restarts at one
      tmo_d = TW'(1);
      if (state_q != S_IDLE && rx_ferr) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!rx_ferr && rx_byte == SYNC_BYTE) begin
              done_d  = 1'b0;
              err_d   = 1'b0;
              wc_d    = '0;
              sum_d   = '0;
              state_d = S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            len_d   = {rx_byte, 8'h00};
            state_d = S_LEN_LO;
          end
          S_LEN_LO: begin
            len_d = w_len_n;
            if (w_len_n > MAX_N) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else if (w_len_n == 16'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DAT_HI;
            end
          end
          S_DAT_HI: begin
            hi_d    = rx_byte;
            sum_d   = sum_q + rx_byte;
            state_d = S_DAT_LO;
          end
          S_DAT_LO: begin
            addr_d  = wc_q;
            data_d  = {hi_q, rx_byte};
            wren_d  = 1'b1;
            wc_d    = wc_q + 16'd1;
            sum_d   = sum_q + rx_byte;
            state_d = (wc_q + 16'd1 == len_q) ? S_CSUM : S_DAT_HI;
          end
          S_CSUM: begin
            done_d  = (rx_byte == sum_q);
            err_d   = (rx_byte != sum_q);
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      err_d   = 1'b1;
      tmo_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      sum_q   <= '0;
      wc_q    <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      sum_q   <= sum_d;
      wc_q    <= wc_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_wren   = wren_q;
  assign cpu_hold   = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule
`default_nettype wire
